// File: rtl/score_disp_pkg.sv
// rtl/score_disp_pkg.sv - shared constants for the score 7-segment display path
package score_disp_pkg;

  // Conversion FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Internal BCD accumulator depth (enough for a 16-bit score)
  localparam int BCD_DIGITS_INT = 5;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit pattern table, entry 0 is the rightmost element
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/score_seg_display_if.sv
// rtl/score_seg_display_if.sv - score in, BCD and segment drive out
interface score_disp_if #(
  parameter int SCORE_W = 16
);
  logic [SCORE_W-1:0] score;
  logic               game_over;
  logic [6:0]         hex0;
  logic [6:0]         hex1;
  logic [6:0]         hex2;
  logic [6:0]         hex3;
  logic [15:0]        bcd_out;
  logic               conv_busy;
  logic               overflow;

  // Game logic side: supplies the score, watches the display
  modport master (
    output score, game_over,
    input  hex0, hex1, hex2, hex3, bcd_out, conv_busy, overflow
  );

  // Display side: consumes the score, drives the digits
  modport slave (
    input  score, game_over,
    output hex0, hex1, hex2, hex3, bcd_out, conv_busy, overflow
  );
endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD nibble to active-low 7-segment pattern
module seg7_decoder
  import score_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Anything outside 0..9 shows as a dark digit
  assign seg = (digit <= 4'd9) ? SEG_TABLE[digit] : SEG_BLANK;

endmodule

// File: rtl/score_seg_display.sv
// rtl/score_seg_display.sv - iterative binary-to-BCD conversion driving four 7-segment digits
module score_seg_display
  import score_disp_pkg::*;
#(
  parameter int SCORE_W   = 16,
  parameter int BLINK_DIV = 25_000_000
) (
  input logic         clk,
  input logic         rst,
  score_disp_if.slave bus
);

  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int BLK_W = $clog2(BLINK_DIV) + 1;
  localparam int ACC_W = BCD_DIGITS_INT * 4;
  localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(SCORE_W - 1);
  localparam logic [BLK_W-1:0] LAST_BLINK = BLK_W'(BLINK_DIV - 1);

  logic [1:0]         state;
  logic [SCORE_W-1:0] last_score;
  logic [SCORE_W-1:0] bin_sr;
  logic [ACC_W-1:0]   bcd_acc;
  logic [ACC_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   iter;
  logic [15:0]        bcd_q;
  logic               ovf_q;
  logic [BLK_W-1:0]   blink_cnt;
  logic               phase_on;
  logic [3:0]         blank;
  logic [6:0]         seg_raw [4];

  // Add-3 correction on every BCD nibble that would overflow past 9 when doubled
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < BCD_DIGITS_INT; i++) begin
      if (bcd_acc[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_acc[i*4 +: 4] + 4'd3;
      else
        bcd_adj[i*4 +: 4] = bcd_acc[i*4 +: 4];
    end
  end

  // Conversion FSM: sample a changed score, run SCORE_W double-dabble steps, commit once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_score <= '0;
      bin_sr     <= '0;
      bcd_acc    <= '0;
      iter       <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.score != last_score) begin
            bin_sr     <= bus.score;
            last_score <= bus.score;
            bcd_acc    <= '0;
            iter       <= '0;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_acc <= (bcd_adj << 1) | ACC_W'(bin_sr[SCORE_W-1]);
          bin_sr  <= bin_sr << 1;
          if (iter == LAST_ITER)
            state <= ST_DONE;
          else
            iter <= iter + 1'b1;
        end
        ST_DONE: begin
          // Anything past 9999 saturates the four visible digits
          if (bcd_acc[ACC_W-1:16] != '0) begin
            bcd_q <= 16'h9999;
            ovf_q <= 1'b1;
          end else begin
            bcd_q <= bcd_acc[15:0];
            ovf_q <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Blink divider: free-runs only during game over, otherwise parks with the display on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!bus.game_over) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == LAST_BLINK) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Leading-zero blanking: a digit goes dark when it and every higher digit is zero
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
  end

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_decoder u_dec (
      .digit (bcd_q[g*4 +: 4]),
      .seg   (seg_raw[g])
    );
  end

  assign bus.hex0      = (!phase_on || blank[0]) ? SEG_BLANK : seg_raw[0];
  assign bus.hex1      = (!phase_on || blank[1]) ? SEG_BLANK : seg_raw[1];
  assign bus.hex2      = (!phase_on || blank[2]) ? SEG_BLANK : seg_raw[2];
  assign bus.hex3      = (!phase_on || blank[3]) ? SEG_BLANK : seg_raw[3];
  assign bus.bcd_out   = bcd_q;
  assign bus.overflow  = ovf_q;
  assign bus.conv_busy = (state == ST_SHIFT) || (state == ST_DONE);

endmodule
